// File: rtl/tab_hash_engine_pkg.sv
// Shared types, default sizes and word helpers for the tabulation hash engine.
// The hash word type is fixed at DBITS_DEF bits; engines must use Dbits == DBITS_DEF.
package tab_hash_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    DONE
  } state_t;

  localparam int KEY_BITS_DEF  = 32;
  localparam int CHAR_BITS_DEF = 8;
  localparam int NLOC_DEF      = 256;
  localparam int DBITS_DEF     = 32;

  typedef logic [DBITS_DEF-1:0] word_t;

  function automatic int nchars(input int key_bits, input int char_bits);
    return key_bits / char_bits;
  endfunction

  // A right shift by the full word width yields zero, so amount 0 is a plain pass-through
  function automatic word_t rotl(input word_t word, input int amount);
    int amt;
    amt = amount % DBITS_DEF;
    return (word << amt) | (word >> (DBITS_DEF - amt));
  endfunction

endpackage

// File: rtl/tab_hash_engine_if.sv
// Key-in and hash-out handshakes of the tabulation hash engine.
// master = key source / hash consumer side, slave = the engine.
interface tab_hash_engine_if #(
  parameter int KEY_BITS = 32,
  parameter int Dbits    = 32
);

  logic                key_valid;
  logic                key_ready;
  logic [KEY_BITS-1:0] key;
  logic                hash_valid;
  logic                hash_ready;
  logic [Dbits-1:0]    hash;

  modport master (
    output key_valid, key, hash_ready,
    input  key_ready, hash_valid, hash
  );

  modport slave (
    input  key_valid, key, hash_ready,
    output key_ready, hash_valid, hash
  );

endinterface

// File: rtl/tab_hash_engine.sv
// Tabulation hash engine: one table lookup per key character, XOR of rotated table words.
// Optional macro TAB_HASH_BACK2BACK_EN lets a new key be accepted in the same cycle the hash retires.
module tab_hash_engine
  import tab_hash_pkg::*;
#(
  parameter int KEY_BITS  = KEY_BITS_DEF,
  parameter int CHAR_BITS = CHAR_BITS_DEF,
  parameter int Nloc      = NLOC_DEF,
  parameter int Dbits     = DBITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tab_hash_engine_if.slave        bus,
  output logic [$clog2(Nloc)-1:0] tbl_addr,
  input  logic [Dbits-1:0]        tbl_data
);

  localparam int NCHARS = nchars(KEY_BITS, CHAR_BITS);
  localparam int IDX_W  = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam int ADDR_W = $clog2(Nloc);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHARS - 1);

  state_t              state;
  state_t              next_state;
  logic [KEY_BITS-1:0] key_reg;
  logic [IDX_W-1:0]    idx;
  logic [Dbits-1:0]    acc;
  logic [Dbits-1:0]    rot_word;
  logic                key_fire;

  logic [CHAR_BITS-1:0] key_chars [NCHARS];

  for (genvar i = 0; i < NCHARS; i++) begin : g_chars
    assign key_chars[i] = key_reg[i*CHAR_BITS +: CHAR_BITS];
  end

  assign key_fire = bus.key_valid && bus.key_ready;
  assign rot_word = Dbits'(rotl(word_t'(tbl_data), int'(idx) * CHAR_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (bus.key_valid) next_state = LOOKUP;
      LOOKUP: if (idx == LAST_IDX) next_state = DONE;
      DONE: begin
        if (bus.hash_ready) begin
`ifdef TAB_HASH_BACK2BACK_EN
          next_state = bus.key_valid ? LOOKUP : IDLE;
`else
          next_state = IDLE;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.key_ready  = 1'b0;
    bus.hash_valid = 1'b0;
    bus.hash       = '0;
    tbl_addr       = '0;
    case (state)
      IDLE:   bus.key_ready = 1'b1;
      LOOKUP: tbl_addr = ADDR_W'(key_chars[idx]);
      DONE: begin
        bus.hash_valid = 1'b1;
        bus.hash       = acc;
`ifdef TAB_HASH_BACK2BACK_EN
        bus.key_ready  = bus.hash_ready;
`endif
      end
      default: ;
    endcase
  end

  // A new key always wins over accumulation; the two never coincide since key_ready is low in LOOKUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg <= '0;
      idx     <= '0;
      acc     <= '0;
    end else if (key_fire) begin
      key_reg <= bus.key;
      idx     <= '0;
      acc     <= '0;
    end else if (state == LOOKUP) begin
      acc <= acc ^ rot_word;
      if (idx != LAST_IDX) idx <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_tab_hash_engine.sv
// Scoreboard bench for tab_hash_engine: directed cases on the replicated-byte table,
// then random keys on a scrambled table with random consumer backpressure.
module tb_tab_hash_engine;
  import tab_hash_pkg::*;

  localparam int NCH = 4;
`ifdef TAB_HASH_BACK2BACK_EN
  localparam int SPACING = 5;
`else
  localparam int SPACING = 6;
`endif

  typedef struct {
    logic [31:0] hash;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  tbl_addr;
  logic [31:0] tbl_data;
  bit          tbl_sel = 1'b0;
  bit          rnd_on = 1'b0;
  bit          prev_valid = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];

  tab_hash_engine_if #(.KEY_BITS(32), .Dbits(32)) bus();

  tab_hash_engine #(
    .KEY_BITS(32), .CHAR_BITS(8), .Nloc(256), .Dbits(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] table_word(input logic [7:0] a, input bit sel);
    logic [31:0] w;
    w = {24'd0, a};
    if (!sel) return w * 32'h01010101;
    return (w * 32'h9E3779B1) ^ {a, 8'h5A, ~a, a ^ 8'hC3};
  endfunction

  assign tbl_data = table_word(tbl_addr, tbl_sel);

  // Reference: rotate-left taken as the top half of a doubled word shifted left
  function automatic logic [31:0] ref_hash(input logic [31:0] k, input bit sel);
    logic [31:0] h, t;
    logic [63:0] dbl;
    h = '0;
    for (int i = 0; i < NCH; i++) begin
      t   = table_word(k[8*i +: 8], sel);
      dbl = {t, t} << (8 * i);
      h   = h ^ dbl[63:32];
    end
    return h;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=no event required=event within bound (t=%0t)", name, $time);
  endtask

  // Offers a key and pushes its expected hash on the negedge before the accepting edge
  task automatic apply_stimulus(input logic [31:0] k, input bit keep, output int acc_cyc);
    bit done;
    done = 1'b0;
    acc_cyc = -1;
    bus.key = k;
    bus.key_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (bus.key_ready && rst_n) begin
        acc_cyc = cyc + 1;
        exp_q.push_back('{ref_hash(k, tbl_sel), cyc + 1});
        done = 1'b1;
      end
    end
    if (!done) report_fail("key_accept_timeout");
    else begin
      @(posedge clk);
      #1;
    end
    if (!keep) bus.key_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) report_fail("scoreboard_drain");
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.hash_valid && !prev_valid) begin
        if (exp_q.size() == 0) report_fail("unexpected_hash_valid");
        else check_output("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(NCH));
      end
      if (bus.hash_valid && bus.hash_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output("hash", bus.hash, e.hash);
      end
      prev_valid = bus.hash_valid;
    end
  end

  initial begin
    #500000;
    report_fail("global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] simulation time bound exceeded");
  end

  initial begin
    int a1, a2, gap;
    bus.key_valid  = 1'b0;
    bus.key        = '0;
    bus.hash_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_key_ready", 32'(bus.key_ready), 32'd1);
    check_output("reset_hash_valid", 32'(bus.hash_valid), 32'd0);
    check_output("reset_tbl_addr", 32'(tbl_addr), 32'd0);
    check_output("reset_hash", bus.hash, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] zero key");
    apply_stimulus(32'h0000_0000, 1'b0, a1);
    drain();

    $display("[TB] address sequence");
    apply_stimulus(32'h0403_0201, 1'b0, a1);
    for (int i = 0; i < NCH; i++) begin
      @(negedge clk);
      check_output("tbl_addr_seq", 32'(tbl_addr), 32'(i + 1));
    end
    @(negedge clk);
    check_output("tbl_addr_done", 32'(tbl_addr), 32'd0);
    drain();

    $display("[TB] backpressure");
    bus.hash_ready = 1'b0;
    apply_stimulus(32'h0000_00FF, 1'b0, a1);
    for (int n = 0; n < 50 && !bus.hash_valid; n++) @(negedge clk);
    if (!bus.hash_valid) report_fail("hash_valid_timeout");
    @(posedge clk);
    #1;
    bus.key = 32'h0000_0055;
    bus.key_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_output("hold_valid", 32'(bus.hash_valid), 32'd1);
      check_output("hold_hash", bus.hash, 32'hFFFF_FFFF);
      check_output("hold_key_ready", 32'(bus.key_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.hash_ready = 1'b1;
    bus.key_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("idle_key_ready", 32'(bus.key_ready), 32'd1);
    check_output("idle_hash_valid", 32'(bus.hash_valid), 32'd0);
    drain();

    $display("[TB] reset mid-lookup");
    apply_stimulus(32'h0403_0201, 1'b0, a1);
    @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_output("abort_key_ready", 32'(bus.key_ready), 32'd1);
    check_output("abort_hash_valid", 32'(bus.hash_valid), 32'd0);
    check_output("abort_tbl_addr", 32'(tbl_addr), 32'd0);
    check_output("abort_hash", bus.hash, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(32'h0403_0201, 1'b0, a1);
    drain();

    $display("[TB] held key_valid");
    apply_stimulus(32'h0000_0001, 1'b1, a1);
    apply_stimulus(32'h0000_0002, 1'b0, a2);
    check_output("accept_spacing", 32'(a2 - a1), 32'(SPACING));
    drain();

    $display("[TB] random keys, scrambled table");
    tbl_sel = 1'b1;
    rnd_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          gap = $urandom_range(0, 2);
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
          apply_stimulus($urandom, 1'b0, a1);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          bus.hash_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.hash_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
